// File: rtl/multi_alarm_set_pkg.sv
// Shared encodings for the alarm setter: the mode bus and the per-channel ring state.
package multi_alarm_set_pkg;

    // Major mode on mode1.
    typedef enum logic [1:0] {
        M1_TIME      = 2'd0,
        M1_ALARM     = 2'd1,
        M1_STOPWATCH = 2'd2,
        M1_DATE      = 2'd3
    } mode1_t;

    // Minor mode on mode2 while in M1_ALARM.
    typedef enum logic [1:0] {
        M2_ALARM_G    = 2'd0,
        M2_ALARM_HOUR = 2'd1,
        M2_ALARM_MIN  = 2'd2,
        M2_ALARM_RSVD = 2'd3
    } mode2_t;

    // Ring state of one alarm channel.
    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_RING = 2'd1,
        A_SNZ  = 2'd2,
        A_DONE = 2'd3
    } alarm_state_t;

    // Width of the snooze and ring-minute counters (both count at most 59).
    localparam int CNT_W = 6;

    // Hour step with wrap 23 -> 0.
    function automatic logic [4:0] next_hour(input logic [4:0] h);
        return (h == 5'd23) ? 5'd0 : h + 5'd1;
    endfunction

    // Minute step with wrap 59 -> 0 and no carry into hours.
    function automatic logic [5:0] next_min(input logic [5:0] m);
        return (m == 6'd59) ? 6'd0 : m + 6'd1;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: hour/minute setting, enable, ring FSM, snooze and ring-minute counters.
module alarm_channel
    import multi_alarm_set_pkg::*;
#(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc_hour,
    input  logic       inc_min,
    input  logic       toggle_en,
    input  logic       set_press,
    input  logic       snooze_press,
    input  logic       minute_tick,
    input  logic [4:0] hours,
    input  logic [5:0] mins,
    output logic [4:0] ch_h,
    output logic [5:0] ch_m,
    output logic       en,
    output logic       ringing
);

    localparam logic [CNT_W-1:0] SNZ_LOAD = CNT_W'(SNOOZE_MIN);
    localparam logic [CNT_W-1:0] RING_LIM = CNT_W'(RING_MIN);

    alarm_state_t     state;
    logic [CNT_W-1:0] snz_cnt;
    logic [CNT_W-1:0] ring_cnt;
    logic             match;

    // Out-of-range time inputs can never equal a stored setting, so they never match.
    assign match   = en && (hours == ch_h) && (mins == ch_m);
    assign ringing = (state == A_RING);

    // Setting registers, enable and ring FSM; edits win over everything and park the channel in IDLE.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch_h     <= '0;
            ch_m     <= '0;
            en       <= 1'b0;
            state    <= A_IDLE;
            snz_cnt  <= '0;
            ring_cnt <= '0;
        end else if (inc_hour || inc_min) begin
            if (inc_hour) ch_h <= next_hour(ch_h);
            if (inc_min)  ch_m <= next_min(ch_m);
            en    <= 1'b1;
            state <= A_IDLE;
        end else begin
            if (toggle_en) en <= ~en;
            if (toggle_en && en) begin
                state <= A_IDLE;
            end else begin
                case (state)
                    A_IDLE: begin
                        if (match) begin
                            state    <= A_RING;
                            ring_cnt <= '0;
                        end
                    end
                    A_RING: begin
                        if (set_press) begin
                            state <= A_DONE;
                        end else if (snooze_press) begin
                            state   <= A_SNZ;
                            snz_cnt <= SNZ_LOAD;
                        end else if (RING_MIN != 0 && minute_tick) begin
                            if (ring_cnt + CNT_W'(1) == RING_LIM) state <= A_DONE;
                            else                                 ring_cnt <= ring_cnt + CNT_W'(1);
                        end
                    end
                    A_SNZ: begin
                        if (set_press) begin
                            state <= A_DONE;
                        end else if (minute_tick) begin
                            snz_cnt <= snz_cnt - CNT_W'(1);
                            if (snz_cnt == CNT_W'(1)) begin
                                state    <= A_RING;
                                ring_cnt <= '0;
                            end
                        end
                    end
                    A_DONE: begin
                        if (!match) state <= A_IDLE;
                    end
                    default: state <= A_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/multi_alarm_set.sv
// Multi-channel alarm setter: button edge detection, channel selection, setting mux and alarm OR.
module multi_alarm_set
    import multi_alarm_set_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int SEL_W      = 2,
    parameter int SNOOZE_MIN = 5,
    parameter int RING_MIN   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  increase,
    input  logic                  set,
    input  logic                  snooze,
    input  logic                  next,
    input  logic [1:0]            mode1,
    input  logic [1:0]            mode2,
    input  logic [4:0]            hours,
    input  logic [5:0]            mins,
    output logic [4:0]            alarm_h,
    output logic [5:0]            alarm_m,
    output logic [SEL_W-1:0]      alarm_sel,
    output logic [NUM_ALARMS-1:0] alarm_en,
    output logic [NUM_ALARMS-1:0] alarm_src,
    output logic                  alarm
);

    logic       inc_q, set_q, snz_q, next_q;
    logic [5:0] mins_q;
    logic       inc_press, set_press, snz_press, next_press, minute_tick;
    logic       in_alarm, edit_h, edit_m, toggle_req, next_req;
    logic [4:0] ch_h [NUM_ALARMS];
    logic [5:0] ch_m [NUM_ALARMS];

    assign inc_press   = increase & ~inc_q;
    assign set_press   = set & ~set_q;
    assign snz_press   = snooze & ~snz_q;
    assign next_press  = next & ~next_q;
    assign minute_tick = (mins != mins_q);

    assign in_alarm   = (mode1 == M1_ALARM);
    assign edit_h     = in_alarm && (mode2 == M2_ALARM_HOUR) && inc_press;
    assign edit_m     = in_alarm && (mode2 == M2_ALARM_MIN) && inc_press;
    // The enable toggle shares the set button, so it is blocked while any channel rings.
    assign toggle_req = in_alarm && (mode2 == M2_ALARM_G) && set_press && !(|alarm_src);
    assign next_req   = in_alarm && (mode2 == M2_ALARM_G) && next_press;

    // Previous-cycle copies of the buttons and minutes for edge and tick detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inc_q  <= 1'b0;
            set_q  <= 1'b0;
            snz_q  <= 1'b0;
            next_q <= 1'b0;
            mins_q <= '0;
        end else begin
            inc_q  <= increase;
            set_q  <= set;
            snz_q  <= snooze;
            next_q <= next;
            mins_q <= mins;
        end
    end

    // Selected channel index, wrapping after the last channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_sel <= '0;
        end else if (next_req) begin
            alarm_sel <= (alarm_sel == SEL_W'(NUM_ALARMS - 1)) ? '0 : alarm_sel + SEL_W'(1);
        end
    end

    generate
        for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
            logic hit;
            assign hit = (alarm_sel == SEL_W'(i));

            alarm_channel #(
                .SNOOZE_MIN(SNOOZE_MIN),
                .RING_MIN  (RING_MIN)
            ) u_ch (
                .clk         (clk),
                .reset_n     (reset_n),
                .inc_hour    (edit_h && hit),
                .inc_min     (edit_m && hit),
                .toggle_en   (toggle_req && hit),
                .set_press   (set_press),
                .snooze_press(snz_press),
                .minute_tick (minute_tick),
                .hours       (hours),
                .mins        (mins),
                .ch_h        (ch_h[i]),
                .ch_m        (ch_m[i]),
                .en          (alarm_en[i]),
                .ringing     (alarm_src[i])
            );
        end
    endgenerate

    // Setting of the selected channel towards the display mux.
    // NOTE: both outputs get a default first so no path through the loop can infer a latch.
    always_comb begin
        alarm_h = '0;
        alarm_m = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (alarm_sel == SEL_W'(i)) begin
                alarm_h = ch_h[i];
                alarm_m = ch_m[i];
            end
        end
    end

    assign alarm = |alarm_src;

endmodule

// File: tb/tb_multi_alarm_set.sv
// Bench for multi_alarm_set: directed scenarios plus random stimulus against a minute-level model.
module tb_multi_alarm_set;
    import multi_alarm_set_pkg::*;

    localparam int N    = 4;
    localparam int SW   = 2;
    localparam int SNZ  = 5;
    localparam int RMIN = 2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          increase, set, snooze, next;
    logic [1:0]    mode1, mode2;
    logic [4:0]    hours;
    logic [5:0]    mins;
    logic [4:0]    alarm_h;
    logic [5:0]    alarm_m;
    logic [SW-1:0] alarm_sel;
    logic [N-1:0]  alarm_en, alarm_src;
    logic          alarm;

    multi_alarm_set #(
        .NUM_ALARMS(N), .SEL_W(SW), .SNOOZE_MIN(SNZ), .RING_MIN(RMIN)
    ) dut (
        .clk(clk), .reset_n(reset_n), .increase(increase), .set(set),
        .snooze(snooze), .next(next), .mode1(mode1), .mode2(mode2),
        .hours(hours), .mins(mins), .alarm_h(alarm_h), .alarm_m(alarm_m),
        .alarm_sel(alarm_sel), .alarm_en(alarm_en), .alarm_src(alarm_src),
        .alarm(alarm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: per channel a setting, an enable and the alarm's situation in plain terms:
    // sounding or not, minutes of snooze left, minutes rung so far, and "dismissed in this minute".
    int mh [N], mm [N], snz_left [N], rung [N];
    bit men [N], sounding [N], dismissed [N];
    int msel, p_mins;
    bit p_inc, p_set, p_snz, p_next;

    function automatic void quiet(input int c);
        sounding[c] = 0; dismissed[c] = 0; snz_left[c] = 0; rung[c] = 0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < N; c++) begin
            mh[c] = 0; mm[c] = 0; men[c] = 0; quiet(c);
        end
        msel = 0; p_mins = 0; p_inc = 0; p_set = 0; p_snz = 0; p_next = 0;
    endfunction

    function automatic void model_step();
        bit ip = increase && !p_inc;
        bit sp = set && !p_set;
        bit zp = snooze && !p_snz;
        bit xp = next && !p_next;
        bit tick = (int'(mins) != p_mins);
        bit amode = (mode1 == M1_ALARM);
        bit any = 0;
        for (int c = 0; c < N; c++) any |= sounding[c];
        for (int c = 0; c < N; c++) begin
            bit here = (c == msel);
            bit hit = men[c] && int'(hours) == mh[c] && int'(mins) == mm[c];
            if (amode && here && ip && mode2 == M2_ALARM_HOUR) begin
                mh[c] = (mh[c] + 1) % 24; men[c] = 1; quiet(c); continue;
            end
            if (amode && here && ip && mode2 == M2_ALARM_MIN) begin
                mm[c] = (mm[c] + 1) % 60; men[c] = 1; quiet(c); continue;
            end
            if (amode && here && sp && mode2 == M2_ALARM_G && !any) begin
                if (men[c]) begin men[c] = 0; quiet(c); continue; end
                men[c] = 1;
            end
            if (sounding[c]) begin
                if (sp) begin sounding[c] = 0; dismissed[c] = 1; end
                else if (zp) begin sounding[c] = 0; snz_left[c] = SNZ; end
                else if (RMIN > 0 && tick) begin
                    rung[c]++;
                    if (rung[c] == RMIN) begin sounding[c] = 0; dismissed[c] = 1; end
                end
            end else if (snz_left[c] > 0) begin
                if (sp) begin snz_left[c] = 0; dismissed[c] = 1; end
                else if (tick) begin
                    snz_left[c]--;
                    if (snz_left[c] == 0) begin sounding[c] = 1; rung[c] = 0; end
                end
            end else if (dismissed[c]) begin
                if (!hit) dismissed[c] = 0;
            end else if (hit) begin
                sounding[c] = 1; rung[c] = 0;
            end
        end
        if (amode && mode2 == M2_ALARM_G && xp) msel = (msel + 1) % N;
        p_inc = increase; p_set = set; p_snz = snooze; p_next = next; p_mins = int'(mins);
    endfunction

    task automatic check_all();
        logic [N-1:0] e_en, e_src;
        for (int c = 0; c < N; c++) begin
            e_en[c] = men[c]; e_src[c] = sounding[c];
        end
        check("alarm_h",   32'(alarm_h),   32'(mh[msel]));
        check("alarm_m",   32'(alarm_m),   32'(mm[msel]));
        check("alarm_sel", 32'(alarm_sel), 32'(msel));
        check("alarm_en",  32'(alarm_en),  32'(e_en));
        check("alarm_src", 32'(alarm_src), 32'(e_src));
        check("alarm",     32'(alarm),     32'(|e_src));
    endtask

    // One clock: the model consumes the inputs seen at the edge, outputs are sampled 1 ns later.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1 check_all();
    endtask

    task automatic press_inc();    increase = 1; cycle(); increase = 0; cycle(); endtask
    task automatic press_set();    set = 1;      cycle(); set = 0;      cycle(); endtask
    task automatic press_snooze(); snooze = 1;   cycle(); snooze = 0;   cycle(); endtask
    task automatic press_next();   next = 1;     cycle(); next = 0;     cycle(); endtask

    task automatic set_time(input int h, input int m);
        hours = 5'(h); mins = 6'(m); cycle(); cycle();
    endtask

    initial begin
        reset_n = 0; increase = 0; set = 0; snooze = 0; next = 0;
        mode1 = M1_TIME; mode2 = M2_ALARM_G; hours = 0; mins = 0;
        model_reset();
        #12 reset_n = 1;

        // Reset state with current time 00:00 must not ring a disabled 00:00 alarm.
        cycle();
        check("rst_h", 32'(alarm_h), 0);
        check("rst_en", 32'(alarm_en), 0);
        check("rst_alarm", 32'(alarm), 0);

        // Hour editing with wrap, then minute editing with wrap and no carry.
        hours = 12; mins = 30;
        mode1 = M1_ALARM; mode2 = M2_ALARM_HOUR;
        for (int i = 0; i < 26; i++) begin
            press_inc();
            check("hour_step", 32'(alarm_h), 32'((i + 1) % 24));
            check("hour_min_hold", 32'(alarm_m), 0);
        end
        mode2 = M2_ALARM_MIN;
        for (int i = 0; i < 70; i++) press_inc();
        check("min_wrap", 32'(alarm_m), 10);
        check("min_no_carry", 32'(alarm_h), 2);
        check("edit_enables", 32'(alarm_en[0]), 1);

        // Ring, dismiss, no retrigger in the same minute, retrigger after leaving it.
        mode1 = M1_TIME;
        set_time(2, 10);
        check("ring_ch0", 32'(alarm_src), 32'h1);
        press_set();
        check("dismiss", 32'(alarm), 0);
        for (int m = 10; m <= 25; m++) begin
            set_time(2, m);
            check("no_retrigger", 32'(alarm), 0);
        end
        set_time(2, 10);
        check("retrigger", 32'(alarm), 1);

        // Snooze for SNZ minutes.
        press_snooze();
        check("snoozed", 32'(alarm), 0);
        for (int m = 11; m <= 14; m++) begin
            set_time(2, m);
            check("snooze_quiet", 32'(alarm), 0);
        end
        set_time(2, 15);
        check("snooze_expire", 32'(alarm), 1);
        press_set();

        // Two channels on 07:00: overlap, common dismiss, auto-silence after RMIN minutes.
        hours = 12; mins = 30;
        mode1 = M1_ALARM; mode2 = M2_ALARM_G;
        press_next();
        check("sel_1", 32'(alarm_sel), 1);
        mode2 = M2_ALARM_HOUR;
        for (int i = 0; i < 7; i++) press_inc();
        mode2 = M2_ALARM_G;
        press_next();
        mode2 = M2_ALARM_HOUR;
        for (int i = 0; i < 7; i++) press_inc();
        check("en_three", 32'(alarm_en), 32'h7);
        mode1 = M1_TIME;
        set_time(7, 0);
        check("overlap", 32'(alarm_src), 32'h6);
        press_set();
        check("overlap_dismiss", 32'(alarm), 0);
        set_time(6, 59);
        set_time(7, 0);
        check("ring_again", 32'(alarm_src), 32'h6);
        set_time(7, 1);
        check("ring_1min", 32'(alarm), 1);
        set_time(7, 2);
        check("auto_silence", 32'(alarm), 0);

        // Asynchronous reset in the middle of a ring.
        set_time(6, 59);
        set_time(7, 0);
        check("pre_reset_ring", 32'(alarm), 1);
        #2 reset_n = 0;
        #1 check("async_rst_alarm", 32'(alarm), 0);
        check("async_rst_src", 32'(alarm_src), 0);
        model_reset();
        @(posedge clk);
        #1 check_all();
        reset_n = 1;
        hours = 12; mins = 30;
        cycle();
        check("post_rst_h", 32'(alarm_h), 0);
        check("post_rst_en", 32'(alarm_en), 0);

        // Random phase: times are often steered onto a channel setting to provoke rings.
        for (int i = 0; i < 2000; i++) begin
            int r, c;
            increase = 1'($urandom_range(0, 1));
            set      = ($urandom_range(0, 3) == 0);
            snooze   = ($urandom_range(0, 3) == 0);
            next     = 1'($urandom_range(0, 1));
            mode1    = ($urandom_range(0, 1) == 0) ? M1_ALARM : 2'($urandom_range(0, 3));
            mode2    = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            c = $urandom_range(0, N - 1);
            if (r < 3) begin
                hours = 5'(mh[c]); mins = 6'(mm[c]);
            end else if (r < 8) begin
                mins = (mins >= 6'd59) ? 6'd0 : mins + 6'd1;
            end else if (r == 9) begin
                hours = 5'($urandom_range(0, 31)); mins = 6'($urandom_range(0, 63));
            end
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_alarm_set.md
Name: multi_alarm_set

Overview:
- Parametrised successor of the single-alarm setter. Holds NUM_ALARMS independent hour/minute alarm channels, each with an enable, a per-channel ring state machine, snooze and an optional auto-silence timeout.
- Sits in the selector beside the timekeeping counters. It takes the current hours/mins and the mode1/mode2 mode bus, and drives the selected alarm's setting to the display mux plus a combined alarm output.

Parameters:
- NUM_ALARMS, 4, number of alarm channels (1..8).
- SEL_W, 2, width of the channel index; must equal max(1, clog2(NUM_ALARMS)).
- SNOOZE_MIN, 5, minutes a snoozed channel stays silent (1..59).
- RING_MIN, 0, minutes after which a ringing channel self-dismisses; 0 means ring until dismissed.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- increase  in  1  step button; one increment per 0->1 transition.
- set  in  1  dismiss, or enable toggle; acts on the 0->1 transition.
- snooze  in  1  snooze button; acts on the 0->1 transition.
- next  in  1  selects the next channel; acts on the 0->1 transition.
- mode1  in  2  major mode (M1_*).
- mode2  in  2  minor mode (M2_*).
- hours  in  5  current hour, 0..23.
- mins  in  6  current minute, 0..59.
- alarm_h  out  5  hour setting of the selected channel.
- alarm_m  out  6  minute setting of the selected channel.
- alarm_sel  out  SEL_W  index of the selected channel.
- alarm_en  out  NUM_ALARMS  per-channel enable bits.
- alarm_src  out  NUM_ALARMS  per-channel ringing bits.
- alarm  out  1  OR of alarm_src.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - every channel is set to 00:00 with en=0 and state IDLE;
  - alarm_sel=0; all outputs are 0;
  - edge-detect registers clear to 0.
  - Reset asserted mid-ring or mid-snooze takes effect immediately.
- Input edges: increase, set, snooze and next each have a registered previous value. A press is in=1 and prev=0, so a held button acts exactly once.
- Minute tick: mins differs from its registered copy from the previous cycle.
- Outputs: alarm_h, alarm_m and alarm_sel are registered state. alarm_src and alarm decode the channel state, so they change one cycle after the triggering condition.
- Editing (only when mode1==M1_ALARM):
  - M2_ALARM_HOUR + increase press: selected hour = (h==23)?0:h+1; minute unchanged.
  - M2_ALARM_MIN + increase press: selected minute = (m==59)?0:m+1; hour unchanged, no carry into hours.
  - Any edit sets the selected channel's en=1 and forces that channel to IDLE.
  - M2_ALARM_G + next press: alarm_sel = (sel==NUM_ALARMS-1)?0:sel+1.
  - M2_ALARM_G + set press, when no channel is ringing: toggle en of the selected channel. A channel whose en goes to 0 goes to IDLE.
- Per-channel FSM (runs in every mode); match = en & hours==ch_h & mins==ch_m.
  - IDLE -> RINGING on match. Ring-minute counter cleared.
  - RINGING -> DONE on a set press. This has priority over the enable toggle and over a simultaneous snooze press.
  - RINGING -> SNOOZED on a snooze press with no set press. Snooze counter loaded with SNOOZE_MIN.
  - RINGING -> DONE when RING_MIN!=0 and RING_MIN minute ticks have elapsed since entering RINGING.
  - SNOOZED: decrement on each minute tick. At 0 -> RINGING with the ring counter cleared. A set press -> DONE (dismisses the snooze).
  - DONE -> IDLE on the first cycle where match=0. This prevents re-triggering within the same alarm minute.
  - Set and snooze presses act on all RINGING channels simultaneously.
- Overlap: several channels may ring at once; alarm_src reflects each channel.
- The hour counter is 5 bits and the minute counter 6 bits; out-of-range inputs (for example hours=31) never match.

Decomposition:
- dclockshare.v holds the existing M1_*/M2_* constants.
- Add to dclockshare.v the channel state encodings: A_IDLE, A_RING, A_SNZ, A_DONE.
- Sub-module alarm_channel, one instance per channel via generate. It contains the hour/minute registers, en, the FSM, and the snooze and ring counters.
- The top level holds the edge detectors, alarm_sel, the output mux and the OR reduction.

Test Plan:
- Reset then clock edge -> alarm_h=0, alarm_m=0, alarm_en=0, alarm=0 even with hours:mins=00:00.
- Select ch0, HOUR mode with 26 increase pulses -> alarm_h steps 1..23,0,1,2, alarm_m stays 0. Then MIN mode with 70 pulses -> alarm_m ends at 10, alarm_h=2, alarm_en[0]=1.
- Set time to 02:10 -> alarm=1 and alarm_src=0001 within 2 cycles. A set press -> alarm=0. Holding 02:10..02:25 -> alarm stays 0. Going 02:11 then back to 02:10 -> rings again.
- Time at 02:10 with SNOOZE_MIN=5: snooze press -> alarm=0. Minutes advance 11..14 -> alarm=0. At 02:15 -> alarm=1.
- ch1 and ch2 both set to 07:00: at 07:00 alarm_src=0110. A single set press clears both. With RING_MIN=2 and no press -> alarm clears at 07:02.
- Channel ringing in M1_TIME: assert reset_n=0 mid-ring -> alarm=0 immediately, and all settings read 0 after release.
